// File: rtl/axi_vga_fetch_sched.sv
// Framebuffer fetch scheduler: 4 KiB-safe, FIFO-credited read bursts per line.
// Optional double-buffer swap is enabled by defining AXI_VGA_DOUBLE_BUF_EN.
module axi_vga_fetch_sched #(
  parameter int AddrWidth = 64,
  parameter int BeatBytes = 8,
  parameter int MaxBurst  = 16,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 frame_start_i,
  input  logic [AddrWidth-1:0] fb_base0_i,
  input  logic [AddrWidth-1:0] fb_base1_i,
  input  logic                 swap_req_i,
  input  logic [AddrWidth-1:0] line_stride_i,
  input  logic [CntWidth-1:0]  line_beats_i,
  input  logic [CntWidth-1:0]  num_lines_i,
  input  logic [8:0]           burst_len_i,
  input  logic [CntWidth-1:0]  fifo_free_i,
  input  logic                 beat_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [7:0]           req_len_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 late_o,
  output logic                 active_buf_o
);

  localparam int BeatShift = $clog2(BeatBytes);

  typedef enum logic [1:0] {IDLE, CALC, REQ} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] line_addr_q, line_addr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] req_addr_q, req_addr_d;
  logic [CntWidth-1:0]  lines_left_q, lines_left_d;
  logic [CntWidth-1:0]  beats_left_q, beats_left_d;
  logic [CntWidth-1:0]  out_q, out_d;
  logic [CntWidth-1:0]  len_q, len_d;
  logic [7:0]           req_len_q, req_len_d;
  logic                 frame_open_q, frame_open_d;
  logic                 issued_q, issued_d;
  logic                 restart_q, restart_d;
  logic                 done_q, done_d;
  logic                 late_q, late_d;
  logic                 active_buf_q, active_buf_d;

  logic                 busy;
  logic                 handshake;
  logic                 restart_req;
  logic                 do_load;
  logic [AddrWidth-1:0] base;
  logic [8:0]           burst_clamp;
  logic [12:0]          bnd_bytes;
  logic [CntWidth-1:0]  bnd_beats;
  logic [CntWidth-1:0]  len_calc;
  logic [CntWidth:0]    credit_need;
  logic                 credit_ok;
  logic                 beat_dec;
  logic [CntWidth:0]    out_sum;
  logic [AddrWidth-1:0] addr_adv;
  logic [AddrWidth-1:0] line_adv;
  logic [CntWidth-1:0]  beats_adv;
  logic [CntWidth-1:0]  lines_adv;

  assign busy        = (state_q != IDLE) || frame_open_q;
  assign handshake   = (state_q == REQ) && req_ready_i;
  assign restart_req = frame_start_i || restart_q;
  assign do_load     = ((state_q == IDLE) && frame_start_i && enable_i)
                    || ((state_q == CALC) && enable_i && restart_req)
                    || (handshake && restart_req);

`ifdef AXI_VGA_DOUBLE_BUF_EN
  logic swap_pend_q, swap_pend_d;

  assign swap_pend_d  = swap_req_i | (swap_pend_q & ~do_load);
  assign active_buf_d = active_buf_q ^ (do_load & swap_pend_q);
  assign base         = active_buf_d ? fb_base1_i : fb_base0_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) swap_pend_q <= 1'b0;
    else       swap_pend_q <= swap_pend_d;
  end
`else
  logic unused_dbuf;

  assign unused_dbuf  = swap_req_i ^ (^fb_base1_i);
  assign active_buf_d = 1'b0;
  assign base         = fb_base0_i;
`endif

  // Burst length: preferred size, line remainder and 4 KiB room, whichever is least.
  always_comb begin
    burst_clamp = burst_len_i;
    if (burst_len_i == 9'd0)
      burst_clamp = 9'd1;
    else if (burst_len_i > 9'(MaxBurst))
      burst_clamp = 9'(MaxBurst);
    len_calc = CntWidth'(burst_clamp);
    if (beats_left_q < len_calc) len_calc = beats_left_q;
    if (bnd_beats < len_calc)    len_calc = bnd_beats;
  end

  assign bnd_bytes   = 13'h1000 - {1'b0, addr_q[11:0]};
  assign bnd_beats   = CntWidth'(bnd_bytes >> BeatShift);
  assign credit_need = {1'b0, out_q} + {1'b0, len_calc};
  assign credit_ok   = credit_need <= {1'b0, fifo_free_i};

  assign beat_dec = beat_i && (out_q != '0);
  assign out_sum  = {1'b0, out_q}
                  + (handshake ? {1'b0, len_q} : '0)
                  - {{CntWidth{1'b0}}, beat_dec};
  assign out_d    = out_sum[CntWidth] ? '1 : out_sum[CntWidth-1:0];

  assign addr_adv  = addr_q + (AddrWidth'(len_q) << BeatShift);
  assign line_adv  = line_addr_q + line_stride_i;
  assign beats_adv = beats_left_q - len_q;
  assign lines_adv = lines_left_q - CntWidth'(1);

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    addr_d       = addr_q;
    req_addr_d   = req_addr_q;
    lines_left_d = lines_left_q;
    beats_left_d = beats_left_q;
    len_d        = len_q;
    req_len_d    = req_len_q;
    frame_open_d = frame_open_q;
    issued_d     = issued_q;
    restart_d    = restart_q;
    done_d       = 1'b0;
    late_d       = frame_start_i && busy;
    if ((state_q == REQ) && frame_start_i && !req_ready_i)
      restart_d = 1'b1;
    unique case (state_q)
      CALC: begin
        if (!enable_i) begin
          state_d   = IDLE;
          restart_d = 1'b0;
        end else if (!restart_req && credit_ok) begin
          req_addr_d = addr_q;
          req_len_d  = 8'(len_calc - CntWidth'(1));
          len_d      = len_calc;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (handshake && !restart_req) begin
          state_d = CALC;
          if (beats_adv == '0) begin
            lines_left_d = lines_adv;
            line_addr_d  = line_adv;
            addr_d       = line_adv;
            beats_left_d = line_beats_i;
            if (lines_adv == '0) begin
              state_d  = IDLE;
              issued_d = 1'b1;
            end
          end else begin
            addr_d       = addr_adv;
            beats_left_d = beats_adv;
          end
        end
      end
      default: ;
    endcase
    if (do_load) begin
      state_d      = CALC;
      line_addr_d  = base;
      addr_d       = base;
      lines_left_d = num_lines_i;
      beats_left_d = line_beats_i;
      frame_open_d = 1'b1;
      issued_d     = 1'b0;
      restart_d    = 1'b0;
    end
    // Frame closes once every request is issued and every beat has landed.
    if (frame_open_q && issued_q && (out_d == '0) && !do_load) begin
      frame_open_d = 1'b0;
      done_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      addr_q       <= '0;
      req_addr_q   <= '0;
      lines_left_q <= '0;
      beats_left_q <= '0;
      out_q        <= '0;
      len_q        <= '0;
      req_len_q    <= '0;
      frame_open_q <= 1'b0;
      issued_q     <= 1'b0;
      restart_q    <= 1'b0;
      done_q       <= 1'b0;
      late_q       <= 1'b0;
      active_buf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      addr_q       <= addr_d;
      req_addr_q   <= req_addr_d;
      lines_left_q <= lines_left_d;
      beats_left_q <= beats_left_d;
      out_q        <= out_d;
      len_q        <= len_d;
      req_len_q    <= req_len_d;
      frame_open_q <= frame_open_d;
      issued_q     <= issued_d;
      restart_q    <= restart_d;
      done_q       <= done_d;
      late_q       <= late_d;
      active_buf_q <= active_buf_d;
    end
  end

  assign req_valid_o  = (state_q == REQ);
  assign req_addr_o   = req_addr_q;
  assign req_len_o    = req_len_q;
  assign busy_o       = busy;
  assign frame_done_o = done_q;
  assign late_o       = late_q;
  assign active_buf_o = active_buf_q;

endmodule

// File: tb/tb_axi_vga_fetch_sched.sv
// Randomized self-checking bench for axi_vga_fetch_sched against a burst-list model.
// Swap expectations follow AXI_VGA_DOUBLE_BUF_EN.
module tb_axi_vga_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        frame_start_i;
  logic [63:0] fb_base0_i;
  logic [63:0] fb_base1_i;
  logic        swap_req_i;
  logic [63:0] line_stride_i;
  logic [15:0] line_beats_i;
  logic [15:0] num_lines_i;
  logic [8:0]  burst_len_i;
  logic [15:0] fifo_free_i;
  logic        beat_i = 1'b0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [63:0] req_addr_o;
  logic [7:0]  req_len_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        late_o;
  logic        active_buf_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_a[$];
  int          cap_l[$];
  logic [63:0] exp_a[$];
  int          exp_l[$];
  int          exp_beats;
  int          pending = 0;
  int          beats_ret = 0;
  int          man_beats = 0;
  bit          auto_beat = 0;
  bit          rand_ready = 0;

  always #5 clk = ~clk;

  axi_vga_fetch_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable_i),
    .frame_start_i (frame_start_i),
    .fb_base0_i    (fb_base0_i),
    .fb_base1_i    (fb_base1_i),
    .swap_req_i    (swap_req_i),
    .line_stride_i (line_stride_i),
    .line_beats_i  (line_beats_i),
    .num_lines_i   (num_lines_i),
    .burst_len_i   (burst_len_i),
    .fifo_free_i   (fifo_free_i),
    .beat_i        (beat_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .req_len_o     (req_len_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .late_o        (late_o),
    .active_buf_o  (active_buf_o)
  );

  // AXI side stand-in: records requests and returns their beats.
  always @(posedge clk) begin
    if (req_valid_o && req_ready_i) begin
      cap_a.push_back(req_addr_o);
      cap_l.push_back(int'(req_len_o) + 1);
      pending += int'(req_len_o) + 1;
    end
    if (beat_i) begin
      pending--;
      beats_ret++;
    end
    #1;
    if (pending > 0 && (man_beats > 0 ||
        (auto_beat && $urandom_range(0, 3) != 0))) begin
      beat_i = 1'b1;
      if (man_beats > 0) man_beats--;
    end else begin
      beat_i = 1'b0;
    end
    if (rand_ready) req_ready_i = ($urandom_range(0, 2) != 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [63:0] b, input logic [63:0] s,
                     input int lb, input int nl, input int bl);
    fb_base0_i    = b;
    line_stride_i = s;
    line_beats_i  = 16'(lb);
    num_lines_i   = 16'(nl);
    burst_len_i   = 9'(bl);
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
  endtask

  // Expected burst list straight from the splitting rules.
  task automatic build_model(input logic [63:0] b, input logic [63:0] s,
                             input int lb, input int nl, input int bl);
    int bc;
    exp_a.delete();
    exp_l.delete();
    exp_beats = 0;
    bc = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
    for (int l = 0; l < nl; l++) begin
      logic [63:0] a;
      int rem;
      a = b + s * 64'(l);
      rem = lb;
      while (rem > 0) begin
        int room, n;
        room = (4096 - int'(a % 4096)) / 8;
        n = bc;
        if (rem < n) n = rem;
        if (room < n) n = room;
        exp_a.push_back(a);
        exp_l.push_back(n);
        exp_beats += n;
        a += 64'(n * 8);
        rem -= n;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      if (frame_done_o) begin
        got = 1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_i = 1'b1;
    frame_start_i = 1'b0;
    fb_base0_i = '0;
    fb_base1_i = '0;
    swap_req_i = 1'b0;
    fifo_free_i = 16'd256;
    cfg(64'h0, 64'h0, 1, 1, 16);
    repeat (2) cyc();
    checks++;
    if ({req_valid_o, busy_o, frame_done_o, late_o, active_buf_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {req_valid_o, busy_o, frame_done_o, late_o, active_buf_o});
    end
    checks++;
    if (req_addr_o !== 64'h0 || req_len_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_req got=%0h/%0h exp=0/0", req_addr_o, req_len_o);
    end
    rst = 1'b0;
    repeat (2) cyc();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_plan_frame();
    bit got;
    cfg(64'h1000, 64'h200, 40, 2, 16);
    fifo_free_i = 16'd256;
    req_ready_i = 1'b1;
    auto_beat = 1;
    cap_a.delete();
    cap_l.delete();
    beats_ret = 0;
    pulse_start();
    checks++;
    if (req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL lat_calc got=%b%b exp=01", req_valid_o, busy_o);
    end
    cyc();
    checks++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 64'h1000 || req_len_o !== 8'd15) begin
      errors++;
      $display("FAIL lat_first got=%b %0h %0d exp=1 1000 15",
               req_valid_o, req_addr_o, req_len_o);
    end
    wait_done(3000, got);
    checks++;
    if (!got || beats_ret != 80 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL plan_done got=%0d beats=%0d busy=%b exp=1 80 0",
               got, beats_ret, busy_o);
    end
    build_model(64'h1000, 64'h200, 40, 2, 16);
    checks++;
    if (cap_a.size() != 6 || exp_a.size() != 6) begin
      errors++;
      $display("FAIL plan_count got=%0d exp=6", cap_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL plan_req%0d got=%0h/%0d exp=%0h/%0d",
                 i, cap_a[i], cap_l[i], exp_a[i], exp_l[i]);
      end
    end
    checks++;
    if (cap_a.size() < 6 || cap_a[5] !== 64'h1300 || cap_l[5] != 8) begin
      errors++;
      $display("FAIL plan_last got=%0d reqs exp=1300/8 last", cap_a.size());
    end
  endtask

  task automatic test_4k();
    bit got;
    cfg(64'hFF0, 64'h0, 40, 1, 16);
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    wait_done(3000, got);
    build_model(64'hFF0, 64'h0, 40, 1, 16);
    checks++;
    if (!got || cap_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL k4_count got=%0d/%0d exp=1/%0d", got, cap_a.size(), exp_a.size());
    end
    checks++;
    if (cap_a.size() < 2 || cap_a[0] !== 64'hFF0 || cap_l[0] != 2 ||
        cap_a[1] !== 64'h1000) begin
      errors++;
      $display("FAIL k4_split got=%0d reqs exp=ff0/2 then 1000", cap_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i] !== exp_a[i] || cap_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL k4_req%0d got=%0h/%0d exp=%0h/%0d",
                 i, cap_a[i], cap_l[i], exp_a[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_credit();
    bit got;
    cfg(64'h2000, 64'h0, 40, 1, 16);
    fifo_free_i = 16'd20;
    auto_beat = 0;
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    repeat (20) cyc();
    checks++;
    if (cap_a.size() != 1 || cap_l[0] != 16 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL credit_hold got=%0d reqs exp=1 of 16", cap_a.size());
    end
    man_beats = 11;
    repeat (16) cyc();
    checks++;
    if (cap_a.size() != 1) begin
      errors++;
      $display("FAIL credit_11 got=%0d exp=1", cap_a.size());
    end
    man_beats = 1;
    repeat (6) cyc();
    checks++;
    if (cap_a.size() != 2 || cap_a[1] !== 64'h2080) begin
      errors++;
      $display("FAIL credit_release got=%0d exp=2", cap_a.size());
    end
    fifo_free_i = 16'd256;
    auto_beat = 1;
    wait_done(3000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL credit_done got=0 exp=1");
    end
  endtask

  task automatic test_stall();
    bit got;
    logic [63:0] a;
    logic [7:0] l;
    cfg(64'h3000, 64'h100, 24, 2, 16);
    req_ready_i = 1'b0;
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    for (int i = 0; i < 10 && !req_valid_o; i++) cyc();
    checks++;
    if (req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid got=%b exp=1", req_valid_o);
    end
    a = req_addr_o;
    l = req_len_o;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (req_valid_o !== 1'b1 || req_addr_o !== a || req_len_o !== l) begin
        errors++;
        $display("FAIL stall_hold%0d got=%b %0h/%0d exp=1 %0h/%0d",
                 i, req_valid_o, req_addr_o, req_len_o, a, l);
      end
    end
    req_ready_i = 1'b1;
    cyc();
    req_ready_i = 1'b0;
    cyc();
    checks++;
    if (cap_a.size() != 1 || cap_a[0] !== 64'h3000) begin
      errors++;
      $display("FAIL stall_one got=%0d exp=1", cap_a.size());
    end
    req_ready_i = 1'b1;
    wait_done(3000, got);
    build_model(64'h3000, 64'h100, 24, 2, 16);
    checks++;
    if (!got || cap_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL stall_total got=%0d/%0d exp=1/%0d", got, cap_a.size(), exp_a.size());
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit seen;
    cfg(64'h4000, 64'h0, 64, 1, 16);
    auto_beat = 0;
    req_ready_i = 1'b1;
    fifo_free_i = 16'd256;
    pulse_start();
    repeat (6) cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (req_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got=%b%b exp=00", req_valid_o, busy_o);
    end
    req_ready_i = 1'b0;
    cyc();
    rst = 1'b0;
    pending = 0;
    cap_a.delete();
    cap_l.delete();
    fifo_free_i = 16'd16;
    req_ready_i = 1'b1;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc();
      seen = cap_a.size() > 0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_credit got=0 reqs exp=1");
    end
    fifo_free_i = 16'd256;
    auto_beat = 1;
    wait_done(3000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_done got=0 exp=1");
    end
  endtask

  task automatic test_late();
    bit got;
    int k;
    cfg(64'h8000, 64'h400, 48, 3, 16);
    req_ready_i = 1'b1;
    auto_beat = 1;
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    for (int i = 0; i < 200 && cap_a.size() < 4; i++) cyc();
    req_ready_i = 1'b0;
    cyc();
    for (int i = 0; i < 10 && !req_valid_o; i++) cyc();
    k = cap_a.size();
    pulse_start();
    checks++;
    if (late_o !== 1'b1) begin
      errors++;
      $display("FAIL late_pulse got=%b exp=1", late_o);
    end
    cyc();
    checks++;
    if (late_o !== 1'b0) begin
      errors++;
      $display("FAIL late_width got=%b exp=0", late_o);
    end
    req_ready_i = 1'b1;
    wait_done(5000, got);
    build_model(64'h8000, 64'h400, 48, 3, 16);
    checks++;
    if (!got || cap_a.size() != k + 1 + exp_a.size()) begin
      errors++;
      $display("FAIL late_count got=%0d/%0d exp=1/%0d", got, cap_a.size(), k + 1 + exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && k + 1 + i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[k+1+i] !== exp_a[i] || cap_l[k+1+i] != exp_l[i]) begin
        errors++;
        $display("FAIL late_req%0d got=%0h/%0d exp=%0h/%0d",
                 i, cap_a[k+1+i], cap_l[k+1+i], exp_a[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit got;
      logic [63:0] b, s;
      int lb, nl, bl;
      b  = {$urandom(), $urandom()} & ~64'h7;
      s  = 64'($urandom_range(0, 'h800)) << 3;
      lb = $urandom_range(1, 40);
      nl = $urandom_range(1, 4);
      bl = $urandom_range(0, 300);
      cfg(b, s, lb, nl, bl);
      fifo_free_i = 16'($urandom_range(16, 256));
      rand_ready = 1;
      auto_beat = 1;
      cap_a.delete();
      cap_l.delete();
      beats_ret = 0;
      pulse_start();
      wait_done(8000, got);
      build_model(b, s, lb, nl, bl);
      checks++;
      if (!got || cap_a.size() != exp_a.size() || beats_ret != exp_beats) begin
        errors++;
        $display("FAIL rnd%0d_frame got=%0d/%0d/%0d exp=1/%0d/%0d",
                 it, got, cap_a.size(), beats_ret, exp_a.size(), exp_beats);
      end
      for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
        checks++;
        if (cap_a[i] !== exp_a[i] || cap_l[i] != exp_l[i]) begin
          errors++;
          $display("FAIL rnd%0d_req%0d got=%0h/%0d exp=%0h/%0d",
                   it, i, cap_a[i], cap_l[i], exp_a[i], exp_l[i]);
        end
      end
    end
    rand_ready = 0;
    req_ready_i = 1'b1;
  endtask

  task automatic test_swap();
    bit got;
    logic [63:0] exp_b;
    logic exp_buf;
`ifdef AXI_VGA_DOUBLE_BUF_EN
    exp_b = 64'h9_0000;
    exp_buf = 1'b1;
`else
    exp_b = 64'h5000;
    exp_buf = 1'b0;
`endif
    fb_base1_i = 64'h9_0000;
    cfg(64'h5000, 64'h0, 32, 2, 16);
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    repeat (3) cyc();
    swap_req_i = 1'b1;
    cyc();
    swap_req_i = 1'b0;
    wait_done(3000, got);
    checks++;
    if (!got || cap_a.size() < 1 || cap_a[0] !== 64'h5000 || active_buf_o !== 1'b0) begin
      errors++;
      $display("FAIL swap_cur got=%0d buf=%b exp=base0 buf0", got, active_buf_o);
    end
    cap_a.delete();
    cap_l.delete();
    pulse_start();
    wait_done(3000, got);
    checks++;
    if (!got || cap_a.size() < 1 || cap_a[0] !== exp_b || active_buf_o !== exp_buf) begin
      errors++;
      $display("FAIL swap_next got=%0d buf=%b exp=%0h buf%b",
               got, active_buf_o, exp_b, exp_buf);
    end
  endtask

  initial begin
    frame_start_i = 1'b0;
    rst = 1'b1;
    test_reset();
    test_plan_frame();
    test_4k();
    test_credit();
    test_stall();
    test_reset_mid();
    test_late();
    test_random();
    test_swap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_vga_fetch_sched.md
# axi_vga_fetch_sched

Framebuffer fetch scheduler for the VGA pipeline. At each frame start it walks the active framebuffer line by line and issues read-burst requests to the AXI read master, sized so that no burst crosses a 4 KiB boundary and the pixel FIFO in front of the timing FSM can never overflow. It also provides an optional glitch-free double-buffer swap.

## Interface
- `AddrWidth`, default 64: request address width.
- `BeatBytes`, default 8: bytes per data beat, power of two.
- `MaxBurst`, default 16: max beats per request, 1..256.
- `CntWidth`, default 16: width of line/beat/credit counters.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  scheduler enable, level.
- `frame_start_i`  in  1  single-cycle pulse, start fetch of a new frame.
- `fb_base0_i`  in  AddrWidth  buffer 0 base, BeatBytes-aligned.
- `fb_base1_i`  in  AddrWidth  buffer 1 base, BeatBytes-aligned.
- `swap_req_i`  in  1  pulse, request buffer swap.
- `line_stride_i`  in  AddrWidth  bytes between line starts.
- `line_beats_i`  in  CntWidth  beats per visible line, ≥1.
- `num_lines_i`  in  CntWidth  visible lines, ≥1.
- `burst_len_i`  in  9  preferred beats per burst, clamped to 1..MaxBurst.
- `fifo_free_i`  in  CntWidth  free beat slots in the pixel FIFO.
- `beat_i`  in  1  one returned beat written into the FIFO this cycle.
- `req_valid_o`  out  1  request valid.
- `req_ready_i`  in  1  request accepted.
- `req_addr_o`  out  AddrWidth  burst start address.
- `req_len_o`  out  8  beats minus one.
- `busy_o`  out  1  frame fetch in progress.
- `frame_done_o`  out  1  pulse, all beats of the frame returned.
- `late_o`  out  1  pulse, `frame_start_i` arrived while busy.
- `active_buf_o`  out  1  buffer currently being fetched.

## Operation
- States: IDLE, CALC, REQ.
- Reset: IDLE; all outputs 0; `outstanding` = 0, `active_buf` = 0, `swap_pend` = 0.
- IDLE: when `frame_start_i` and `enable_i` are both high, apply a pending swap (toggle `active_buf`, clear `swap_pend`), load `line_addr` = selected base, `lines_left` = `num_lines_i`, `beats_left` = `line_beats_i`, `addr` = `line_addr`, and go to CALC.
- CALC: compute `len` = min(clamped `burst_len_i`, `beats_left`, beats until the next 4 KiB boundary of `addr`).
  - If `outstanding + len ≤ fifo_free_i` and `enable_i` is high: register the request and go to REQ.
  - Otherwise stay in CALC.
  - `enable_i` low in CALC: go to IDLE.
- REQ: `req_valid_o` is high, and address and length are held stable until `req_ready_i`. On handshake:
  - `outstanding += len`; `addr += len*BeatBytes`; `beats_left -= len`.
  - If `beats_left` reaches 0: `lines_left -= 1`, `line_addr += line_stride_i`, `addr` = `line_addr`, `beats_left` = `line_beats_i`.
  - If `lines_left` reaches 0: go to IDLE. Otherwise go to CALC.
- `outstanding` decrements by 1 per `beat_i`. Handshake and beat in the same cycle net to `+len-1`.
- `busy_o` = state ≠ IDLE OR `frame_open`. `frame_open` is set at frame start and cleared when the last request has handshaked and `outstanding` reaches 0. `frame_done_o` pulses in the cycle `frame_open` clears.
- `frame_start_i` while busy: pulse `late_o`. The current request completes its handshake, then the fetch restarts from the frame's first line (as in IDLE). Returned beats of the old frame are still counted.
- `swap_req_i` sets `swap_pend`. The swap takes effect only at a frame start.
- Arithmetic: address adds wrap modulo 2^AddrWidth. `outstanding` saturates at its maximum and never underflows; a `beat_i` with `outstanding` = 0 is ignored.

## Timing
- `frame_start_i` → first `req_valid_o`: 2 cycles (IDLE→CALC→REQ) when credit is available.
- Maximum rate: one request every 2 cycles.
- `req_*` outputs are registered and never change while `req_valid_o && !req_ready_i`.
- `frame_done_o` is registered, 1 cycle after the last beat.
- Reset asserted mid-burst: the block returns to IDLE immediately and `outstanding` is cleared. The AXI side must be reset together with this block.

## Configuration
- `AXI_VGA_DOUBLE_BUF_EN` defined: `fb_base1_i` and `swap_req_i` are functional as described.
- `AXI_VGA_DOUBLE_BUF_EN` undefined: `swap_req_i` and `fb_base1_i` are ignored, `active_buf_o` is constant 0, and `fb_base0_i` is always used.

## Test plan
- Base 0x1000, `line_beats_i`=40, `burst_len_i`=16, `num_lines_i`=2, stride 0x200, `fifo_free_i`=256 → requests (0x1000,15),(0x1080,15),(0x1100,7),(0x1200,15),(0x1280,15),(0x1300,7); `frame_done_o` after 80 beats.
- Base 0xFF0 (2 beats to the 4 KiB boundary), `burst_len_i`=16 → first request len 1 (2 beats) at 0xFF0, next at 0x1000.
- `fifo_free_i`=20, no beats returned → exactly one 16-beat request, then held in CALC. Returning 12 beats releases the next request.
- `req_ready_i` held low for 10 cycles → `req_addr_o`/`req_len_o` stable throughout. One request per handshake.
- `frame_start_i` mid-frame → `late_o` pulses 1 cycle, and the next request after the pending handshake is at the base address.
- (`AXI_VGA_DOUBLE_BUF_EN`) `swap_req_i` mid-frame → current frame stays on base0, the next frame starts at base1, and `active_buf_o`=1.
